// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings.
// The encoding 2'd3 is never produced; the FSM treats it as IDLE.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Full adder built from two half adders with an OR of their carries.
// Purely combinational, zero latency, no flow control.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    logic s0, c0, c1;

    half_adder u_ha0 (.a(A),  .b(B),   .s(s0),  .c(c0));
    half_adder u_ha1 (.a(s0), .b(Cin), .s(Sum), .c(c1));

    assign Cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Half adder cell: s = a ^ b, c = a & b.
// Purely combinational, zero latency, no flow control.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: {Cout,Sum} = A + B + Cin, one bit per clock, LSB first.
// Latency WIDTH+1 cycles from accept to done; start is ignored while busy or done.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    import serial_adder_pkg::*;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_c;

    full_adder u_fa (
        .A   (a_sh[0]),
        .B   (b_sh[0]),
        .Cin (carry),
        .Sum (fa_s),
        .Cout(fa_c)
    );

    // The new sum bit enters at the MSB so the LSB-first result ends up aligned.
    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_nxt = fa_s;
        end else begin : g_wn
            assign sum_nxt = {fa_s, sum_sh[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE: state_nxt = start ? ST_RUN : ST_IDLE;
            ST_RUN:  state_nxt = (cnt == LAST) ? ST_DONE : ST_RUN;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_RUN);
        done = (state == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            Sum    <= '0;
            Cout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh   <= A;
                        b_sh   <= B;
                        carry  <= Cin;
                        cnt    <= '0;
                        sum_sh <= '0;
                    end
                end
                ST_RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_nxt;
                    carry  <= fa_c;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        Sum  <= sum_nxt;
                        Cout <= fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
